pmem_loader: RTL and testbench

- Byte-stream program loader that writes 32-bit instruction words into the program-memory BRAM write port. It is the writer side of the memory that the CPU fetch path only reads.
- Sits between a byte source (UART RX or a debug bridge) and the program BRAM.
- Holds the CPU in reset while a frame is loaded, validates the frame checksum, then releases the CPU.

---
 rtl/pmem_loader_if.sv | 43 ++++
 rtl/pmem_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_pmem_loader.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_loader_if.sv
// -----------------------------------------------------------------------------
// pmem_loader_if
// Bundles the two buses of the program loader:
//   - byte stream from the source (UART RX / debug bridge):
//       in_valid  source -> loader   byte on in_data is valid
//       in_data   source -> loader   8-bit byte
//       in_ready  loader -> source   loader takes in_data this cycle
//   - program BRAM write port:
//       wr_addr   loader -> BRAM     word write address
//       wr_data   loader -> BRAM     32-bit write data
//       byte_w_en loader -> BRAM     per-byte write enables
// Modports:
//   master : the side that feeds bytes and watches the BRAM port (source/bench)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface pmem_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           wr_data;
   logic [3:0]            byte_w_en;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  wr_addr,
      input  wr_data,
      input  byte_w_en
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output wr_addr,
      output wr_data,
      output byte_w_en
   );
endinterface

// File: rtl/pmem_loader.sv
// -----------------------------------------------------------------------------
// pmem_loader
// Byte-stream program loader. Receives a frame
//    LEN_LO, LEN_HI, 4*N payload bytes (little-endian words), XOR checksum
// writes each assembled 32-bit word into the program BRAM starting at
// BASE_ADDR (wrapping modulo the BRAM depth), keeps the CPU in reset while
// loading and releases it only after a frame with a good checksum.
//
// Ports:
//   sysclk    in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle pulse opening a load session (ignored while busy)
//   bus       slave modport of pmem_loader_if (byte stream + BRAM write port)
//   cpu_hold  out  high keeps the CPU in reset
//   busy      out  frame in progress
//   done      out  last frame loaded with good checksum (sticky)
//   err       out  last frame failed (sticky)
//
// All outputs are registers. in_ready is a decode of the registered state,
// so there is no combinational path from in_valid to in_ready.
// -----------------------------------------------------------------------------
module pmem_loader #(
   parameter int ADDR_WIDTH     = 12,
   parameter int BASE_ADDR      = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         sysclk,
   input  logic         rst,
   input  logic         start,
   pmem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]           MAX_WORDS = 17'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CKSUM  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   // Running frame checksum: XOR of all payload bytes.
   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   state_t                state_r;
   state_t                state_nx_s;

   logic [7:0]            len_lo_r;
   logic [15:0]           len_r;
   logic [1:0]            byte_idx_r;
   logic [15:0]           word_idx_r;
   logic [23:0]           asm_r;
   logic [7:0]            acc_r;
   logic [CNT_W-1:0]      idle_cnt_r;

   logic                  in_ready_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  err_r;
   logic                  cpu_hold_r;
   logic [ADDR_WIDTH-1:0] wr_addr_r;
   logic [31:0]           wr_data_r;
   logic [3:0]            byte_w_en_r;

   logic                  active_s;
   logic                  accept_s;
   logic                  start_take_s;
   logic                  timeout_s;
   logic [15:0]           len_s;
   logic                  word_done_s;
   logic                  last_word_s;
   logic                  in_ready_nx_s;
   logic                  done_nx_s;
   logic                  err_nx_s;
   logic                  hold_nx_s;

   assign bus.in_ready  = in_ready_r;
   assign bus.wr_addr   = wr_addr_r;
   assign bus.wr_data   = wr_data_r;
   assign bus.byte_w_en = byte_w_en_r;
   assign cpu_hold      = cpu_hold_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign err           = err_r;

   assign accept_s     = bus.in_valid && in_ready_r;
   assign start_take_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
   assign timeout_s    = active_s && !accept_s && (idle_cnt_r == TO_LAST);
   assign len_s        = {bus.in_data, len_lo_r};
   assign word_done_s  = (state_r == ST_DATA) && accept_s && (byte_idx_r == 2'd3);
   assign last_word_s  = (word_idx_r == (len_r - 16'd1));

   // Frame states in which bytes are taken and the idle timer runs.
   always_comb begin
      active_s = 1'b0;
      case (state_r)
         ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CKSUM: active_s = 1'b1;
         default:                                 active_s = 1'b0;
      endcase
   end

   // Next-state logic and next values of the status outputs.
   always_comb begin
      state_nx_s    = state_r;
      in_ready_nx_s = 1'b0;
      done_nx_s     = 1'b0;
      err_nx_s      = 1'b0;
      hold_nx_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_take_s) begin
               state_nx_s = ST_LEN_LO;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_LEN_LO: begin
            if (accept_s) begin
               state_nx_s = ST_LEN_HI;
            end else if (timeout_s) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_LEN_LO;
            end
         end
         ST_LEN_HI: begin
            if (accept_s) begin
               if (len_s == 16'd0) begin
                  state_nx_s = ST_CKSUM;
               end else if ({1'b0, len_s} > MAX_WORDS) begin
                  // Frame larger than the BRAM: reject before writing anything.
                  state_nx_s = ST_ERR;
               end else begin
                  state_nx_s = ST_DATA;
               end
            end else if (timeout_s) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_LEN_HI;
            end
         end
         ST_DATA: begin
            if (word_done_s && last_word_s) begin
               state_nx_s = ST_CKSUM;
            end else if (accept_s) begin
               state_nx_s = ST_DATA;
            end else if (timeout_s) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         ST_CKSUM: begin
            if (accept_s) begin
               if (bus.in_data == acc_r) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_ERR;
               end
            end else if (timeout_s) begin
               state_nx_s = ST_ERR;
            end else begin
               state_nx_s = ST_CKSUM;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase

      // Status follows the state being entered, so every output is a flop.
      case (state_nx_s)
         ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CKSUM: begin
            in_ready_nx_s = 1'b1;
            hold_nx_s     = 1'b1;
         end
         ST_DONE: begin
            done_nx_s = 1'b1;
         end
         ST_ERR: begin
            err_nx_s  = 1'b1;
            hold_nx_s = 1'b1;
         end
         default: begin
            in_ready_nx_s = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Registered handshake and status outputs.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         cpu_hold_r <= 1'b0;
      end else begin
         in_ready_r <= in_ready_nx_s;
         busy_r     <= in_ready_nx_s;
         done_r     <= done_nx_s;
         err_r      <= err_nx_s;
         cpu_hold_r <= hold_nx_s;
      end
   end

   // Idle-cycle timer: cleared by start and by every accepted byte.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         idle_cnt_r <= '0;
      end else if (start_take_s || accept_s || !active_s) begin
         idle_cnt_r <= '0;
      end else begin
         idle_cnt_r <= idle_cnt_r + CNT_W'(1);
      end
   end

   // Length capture, lane assembly, checksum and word counter.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         len_lo_r   <= 8'd0;
         len_r      <= 16'd0;
         byte_idx_r <= 2'd0;
         word_idx_r <= 16'd0;
         asm_r      <= 24'd0;
         acc_r      <= 8'd0;
      end else if (start_take_s) begin
         byte_idx_r <= 2'd0;
         word_idx_r <= 16'd0;
         acc_r      <= 8'd0;
      end else if (accept_s && (state_r == ST_LEN_LO)) begin
         len_lo_r <= bus.in_data;
      end else if (accept_s && (state_r == ST_LEN_HI)) begin
         len_r <= len_s;
      end else if (accept_s && (state_r == ST_DATA)) begin
         acc_r      <= csum_next(acc_r, bus.in_data);
         byte_idx_r <= byte_idx_r + 2'd1;
         case (byte_idx_r)
            2'd0:    asm_r[7:0]   <= bus.in_data;
            2'd1:    asm_r[15:8]  <= bus.in_data;
            2'd2:    asm_r[23:16] <= bus.in_data;
            default: word_idx_r   <= word_idx_r + 16'd1;
         endcase
      end else begin
         acc_r <= acc_r;
      end
   end

   // BRAM write port: one-cycle pulse in the cycle after a word's 4th byte.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         wr_addr_r   <= '0;
         wr_data_r   <= 32'd0;
         byte_w_en_r <= 4'h0;
      end else if (word_done_s) begin
         wr_addr_r   <= BASE + word_idx_r[ADDR_WIDTH-1:0];
         wr_data_r   <= {bus.in_data, asm_r};
         byte_w_en_r <= 4'hF;
      end else begin
         byte_w_en_r <= 4'h0;
      end
   end

endmodule

// File: tb/tb_pmem_loader.sv
// -----------------------------------------------------------------------------
// tb_pmem_loader
// Two loaders (BASE_ADDR 0 and 0xFFF, TIMEOUT_CYCLES 16) share one byte
// stream. Frames are built from random words; the expected BRAM writes and
// final status are derived from the frame rules and compared with what a
// negedge monitor records on each BRAM write port.
// -----------------------------------------------------------------------------
module tb_pmem_loader;

   logic       sysclk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       hold0, busy0, done0, err0;
   logic       hold1, busy1, done1, err1;

   always #5 sysclk = ~sysclk;

   pmem_loader_if #(.ADDR_WIDTH(12)) bus0 ();
   pmem_loader_if #(.ADDR_WIDTH(12)) bus1 ();

   assign bus0.in_valid = in_valid;
   assign bus0.in_data  = in_data;
   assign bus1.in_valid = in_valid;
   assign bus1.in_data  = in_data;

   pmem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)) dut0 (
      .sysclk(sysclk), .rst(rst), .start(start), .bus(bus0),
      .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0));

   pmem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(4095), .TIMEOUT_CYCLES(16)) dut1 (
      .sysclk(sysclk), .rst(rst), .start(start), .bus(bus1),
      .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1));

   typedef struct packed {
      logic [3:0]  be;
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;

   int          checks   = 0;
   int          failures = 0;
   int          cyc;
   wr_t         wq0[$];
   wr_t         wq1[$];
   int          acc_cyc[$];
   int          pulse_cyc[$];
   int          adj_cnt;
   bit          prev_pulse;
   logic [7:0]  frm[$];
   logic [31:0] exp_w[$];
   bit          exp_good;
   int          busy_start_idx = -1;

   // Monitor: record accepted bytes and write pulses, sampled on the falling edge.
   initial begin
      cyc = 0;
      prev_pulse = 1'b0;
      adj_cnt = 0;
      forever begin
         @(negedge sysclk);
         cyc++;
         if (rst) begin
            if (in_valid && bus0.in_ready) acc_cyc.push_back(cyc);
            if (bus0.byte_w_en != 4'h0) begin
               wq0.push_back({bus0.byte_w_en, bus0.wr_addr, bus0.wr_data});
               pulse_cyc.push_back(cyc);
               if (prev_pulse) adj_cnt++;
               prev_pulse = 1'b1;
            end else begin
               prev_pulse = 1'b0;
            end
            if (bus1.byte_w_en != 4'h0) wq1.push_back({bus1.byte_w_en, bus1.wr_addr, bus1.wr_data});
         end else begin
            prev_pulse = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic clear_mon();
      wq0.delete();
      wq1.delete();
      acc_cyc.delete();
      pulse_cyc.delete();
      adj_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit also_start);
      int n;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = b;
      start    = also_start;
      n = 0;
      while (1) begin
         @(negedge sysclk);
         if (bus0.in_ready) break;
         n++;
         if (n > 40) begin
            checks++;
            failures++;
            $display("FAIL byte_wait: in_ready=%0b after 40 cycles, required 1", bus0.in_ready);
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Frame of n random words; bad corrupts the checksum byte.
   task automatic build_frame(input int n, input bit bad);
      logic [31:0] w;
      logic [7:0]  ck;
      logic [15:0] nn;
      nn = 16'(n);
      frm.delete();
      exp_w.delete();
      ck = 8'h00;
      frm.push_back(nn[7:0]);
      frm.push_back(nn[15:8]);
      if (n <= 4096) begin
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_w.push_back(w);
            for (int k = 0; k < 4; k++) begin
               ck = ck ^ w[8*k +: 8];
               frm.push_back(w[8*k +: 8]);
            end
         end
         if (bad) ck = ck ^ 8'($urandom_range(1, 255));
         frm.push_back(ck);
      end
      exp_good = !bad && (n <= 4096);
   endtask

   task automatic build_fixed(input logic [7:0] ck);
      frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, ck};
      exp_w = '{32'h0000_0013, 32'h0000_006F};
      exp_good = (ck == 8'h7C);
   endtask

   task automatic play_frame(input int maxgap);
      clear_mon();
      pulse_start();
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, (i == busy_start_idx));
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      logic [52:0] v0, v1;
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) tick();
      v0 = {bus0.in_ready, bus0.byte_w_en, busy0, done0, err0, hold0, bus0.wr_addr, bus0.wr_data};
      v1 = {bus1.in_ready, bus1.byte_w_en, busy1, done1, err1, hold1, bus1.wr_addr, bus1.wr_data};
      checks++;
      if ((v0 !== 53'd0) || (v1 !== 53'd0)) begin
         failures++;
         $display("FAIL reset_values: got %h / %h, required 0", v0, v1);
      end
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if ({busy0, done0, err0, hold0, bus0.in_ready} !== 5'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy/done/err/hold/rdy=%b, required 00000",
                  {busy0, done0, err0, hold0, bus0.in_ready});
      end
   endtask

   task automatic test_basic_frame();
      build_fixed(8'h7C);
      play_frame(0);
      checks++;
      if (wq0.size() != 2) begin
         failures++;
         $display("FAIL basic_writes0: count=%0d, required 2", wq0.size());
      end else if ((wq0[0] !== {4'hF, 12'h000, 32'h0000_0013}) || (wq0[1] !== {4'hF, 12'h001, 32'h0000_006F})) begin
         failures++;
         $display("FAIL basic_writes0: got %h %h, required f00000000013 f0010000006f", wq0[0], wq0[1]);
      end
      checks++;
      if (wq1.size() != 2) begin
         failures++;
         $display("FAIL wrap_writes1: count=%0d, required 2", wq1.size());
      end else if ((wq1[0] !== {4'hF, 12'hFFF, 32'h0000_0013}) || (wq1[1] !== {4'hF, 12'h000, 32'h0000_006F})) begin
         failures++;
         $display("FAIL wrap_writes1: got %h %h, required ffff00000013 f0000000006f", wq1[0], wq1[1]);
      end
      checks++;
      if ({done0, err0, hold0, busy0, done1, err1, hold1, busy1} !== 8'b1000_1000) begin
         failures++;
         $display("FAIL basic_status: done/err/hold/busy=%b, required 10001000",
                  {done0, err0, hold0, busy0, done1, err1, hold1, busy1});
      end
   endtask

   task automatic test_bad_checksum();
      build_fixed(8'h00);
      play_frame(2);
      checks++;
      if (wq0.size() != 2) begin
         failures++;
         $display("FAIL bad_ck_writes: count=%0d, required 2", wq0.size());
      end else if ((wq0[0].d !== 32'h13) || (wq0[1].d !== 32'h6F)) begin
         failures++;
         $display("FAIL bad_ck_writes: got %h %h, required 00000013 0000006f", wq0[0].d, wq0[1].d);
      end
      checks++;
      if ({done0, err0, hold0, busy0} !== 4'b0110) begin
         failures++;
         $display("FAIL bad_ck_status: done/err/hold/busy=%b, required 0110", {done0, err0, hold0, busy0});
      end
      build_fixed(8'h7C);
      play_frame(0);
      checks++;
      if ({done0, err0, hold0, busy0} !== 4'b1000) begin
         failures++;
         $display("FAIL recover_status: done/err/hold/busy=%b, required 1000", {done0, err0, hold0, busy0});
      end
   endtask

   task automatic test_zero_and_oversize();
      build_frame(0, 1'b0);
      play_frame(0);
      checks++;
      if ((wq0.size() != 0) || (wq1.size() != 0) || ({done0, err0, hold0} !== 3'b100)) begin
         failures++;
         $display("FAIL zero_len: writes=%0d done/err/hold=%b, required 0 100", wq0.size(), {done0, err0, hold0});
      end
      build_frame(16'h1001, 1'b0);
      play_frame(0);
      checks++;
      if ((wq0.size() != 0) || ({done0, err0, hold0, busy0, bus0.in_ready} !== 5'b01100)) begin
         failures++;
         $display("FAIL oversize: writes=%0d done/err/hold/busy/rdy=%b, required 0 01100",
                  wq0.size(), {done0, err0, hold0, busy0, bus0.in_ready});
      end
   endtask

   task automatic test_back_to_back();
      int bad_seq;
      build_frame(3, 1'b0);
      play_frame(0);
      bad_seq = 0;
      if (acc_cyc.size() == 15) begin
         for (int i = 1; i < 15; i++) if (acc_cyc[i] != acc_cyc[0] + i) bad_seq++;
      end
      checks++;
      if ((acc_cyc.size() != 15) || (bad_seq != 0)) begin
         failures++;
         $display("FAIL b2b_accept: accepted=%0d gaps=%0d, required 15 0", acc_cyc.size(), bad_seq);
      end
      bad_seq = 0;
      if ((pulse_cyc.size() == 3) && (acc_cyc.size() == 15)) begin
         for (int k = 0; k < 3; k++) if (pulse_cyc[k] != acc_cyc[2 + 4*k + 3] + 1) bad_seq++;
      end
      checks++;
      if ((pulse_cyc.size() != 3) || (bad_seq != 0) || (adj_cnt != 0)) begin
         failures++;
         $display("FAIL b2b_pulse: pulses=%0d misplaced=%0d adjacent=%0d, required 3 0 0",
                  pulse_cyc.size(), bad_seq, adj_cnt);
      end
      checks++;
      if ((wq0.size() != 3) || (wq0[0].d !== exp_w[0]) || (wq0[1].d !== exp_w[1]) || (wq0[2].d !== exp_w[2])
          || (done0 !== 1'b1)) begin
         failures++;
         $display("FAIL b2b_data: writes=%0d done=%0b, required 3 1", wq0.size(), done0);
      end
   endtask

   task automatic test_random_frames();
      int  n;
      int  bad_ent;
      wr_t e0, e1;
      for (int f = 0; f < 8; f++) begin
         n = $urandom_range(1, 6);
         build_frame(n, ($urandom_range(0, 3) == 0));
         busy_start_idx = (f == 2) ? 4 : -1;
         play_frame(3);
         busy_start_idx = -1;
         bad_ent = 0;
         if ((wq0.size() == n) && (wq1.size() == n)) begin
            for (int i = 0; i < n; i++) begin
               e0 = {4'hF, 12'(i), exp_w[i]};
               e1 = {4'hF, 12'(4095 + i), exp_w[i]};
               if ((wq0[i] !== e0) || (wq1[i] !== e1)) bad_ent++;
            end
         end
         checks++;
         if ((wq0.size() != n) || (wq1.size() != n) || (bad_ent != 0)) begin
            failures++;
            $display("FAIL rand_writes f%0d: writes=%0d/%0d wrong=%0d, required %0d 0",
                     f, wq0.size(), wq1.size(), bad_ent, n);
         end
         checks++;
         if ({done0, err0, hold0, busy0, done1, err1} !== {exp_good, !exp_good, !exp_good, 1'b0, exp_good, !exp_good}) begin
            failures++;
            $display("FAIL rand_status f%0d: done/err/hold/busy/done1/err1=%b, required good=%0b",
                     f, {done0, err0, hold0, busy0, done1, err1}, exp_good);
         end
      end
   endtask

   task automatic test_nonconsume();
      build_frame(1, 1'b0);
      clear_mon();
      in_valid = 1'b1;
      in_data  = frm[0];
      repeat (4) tick();
      checks++;
      if ((acc_cyc.size() != 0) || (bus0.in_ready !== 1'b0)) begin
         failures++;
         $display("FAIL not_ready_hold: accepted=%0d rdy=%0b, required 0 0", acc_cyc.size(), bus0.in_ready);
      end
      pulse_start();
      for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 0, 1'b0);
      repeat (3) tick();
      checks++;
      if ((wq0.size() != 1) || (wq0[0].d !== exp_w[0]) || (done0 !== 1'b1)) begin
         failures++;
         $display("FAIL held_byte_frame: writes=%0d done=%0b, required 1 1", wq0.size(), done0);
      end
   endtask

   task automatic test_timeout();
      logic e15, e17;
      build_frame(3, 1'b0);
      clear_mon();
      pulse_start();
      for (int i = 0; i < 7; i++) send_byte(frm[i], 0, 1'b0);
      e15 = 1'b0;
      e17 = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge sysclk);
         if (k == 15) e15 = err0 | err1;
         if (k == 17) e17 = err0 & err1;
      end
      checks++;
      if ((e15 !== 1'b0) || (e17 !== 1'b1)) begin
         failures++;
         $display("FAIL timeout_edge: err@15=%0b err@17=%0b, required 0 1", e15, e17);
      end
      checks++;
      if ((wq0.size() != 1) || (wq0[0] !== {4'hF, 12'h000, exp_w[0]}) || ({hold0, busy0, done0} !== 3'b100)) begin
         failures++;
         $display("FAIL timeout_state: writes=%0d hold/busy/done=%b, required 1 100",
                  wq0.size(), {hold0, busy0, done0});
      end
   endtask

   task automatic test_reset_midword();
      logic [52:0] v0;
      clear_mon();
      pulse_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'hAA, 0, 1'b0);
      send_byte(8'hBB, 0, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'hCC;
      @(posedge sysclk);
      #3;
      rst = 1'b0;
      #1;
      v0 = {bus0.in_ready, bus0.byte_w_en, busy0, done0, err0, hold0, bus0.wr_addr, bus0.wr_data};
      checks++;
      if (v0 !== 53'd0) begin
         failures++;
         $display("FAIL async_reset: outputs=%h, required 0", v0);
      end
      in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (6) tick();
      checks++;
      if ((wq0.size() != 0) || ({busy0, done0, err0, hold0} !== 4'b0000)) begin
         failures++;
         $display("FAIL reset_no_write: writes=%0d busy/done/err/hold=%b, required 0 0000",
                  wq0.size(), {busy0, done0, err0, hold0});
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_bad_checksum();
      test_zero_and_oversize();
      test_back_to_back();
      test_random_frames();
      test_nonconsume();
      test_timeout();
      test_reset_midword();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
